// File: rtl/tpu_pkg.sv
// -----------------------------------------------------------------------------
// tpu_pkg
// Shared definitions for the 2x2 TPU instruction sequencer: instruction field
// positions, opcode and FSM state encodings, and an opcode decoder that folds
// the illegal opcodes onto NOP.
// -----------------------------------------------------------------------------
package tpu_pkg;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 13;
    localparam int ADDR_W  = 13;

    typedef enum logic [2:0] {
        OP_NOP    = 3'b000,
        OP_LDW    = 3'b001,
        OP_LDI    = 3'b010,
        OP_MATMUL = 3'b011,
        OP_HALT   = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LDW,
        ST_LDI,
        ST_COMPUTE,
        ST_HALT
    } seq_state_t;

    // Opcodes 100..110 have no meaning and are consumed as NOP.
    function automatic opcode_t decode_opcode(input logic [15:0] instr);
        logic [2:0] raw;
        raw = instr[OPC_MSB:OPC_LSB];
        case (raw)
            OP_LDW:    return OP_LDW;
            OP_LDI:    return OP_LDI;
            OP_MATMUL: return OP_MATMUL;
            OP_HALT:   return OP_HALT;
            default:   return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/seq_timer.sv
// -----------------------------------------------------------------------------
// seq_timer
// Cycle counter bounding the time the sequencer may spend in COMPUTE.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : force the count to zero (has priority over enable)
//   enable     : advance the count by one per cycle
//   expired    : count has reached TIMEOUT-1; the counter holds there
// -----------------------------------------------------------------------------
module seq_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign expired = (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples the pre-edge value, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/tpu_sequencer.sv
// -----------------------------------------------------------------------------
// tpu_sequencer
// Instruction sequencer for the 2x2 TPU datapath. Accepts 16-bit instructions
// over valid/ready, decodes them and drives the datapath control strobes.
// A MATMUL holds `valid` until both accumulators have reported full (or the
// timer expires), then pulses `done`. HALT parks the sequencer until reset.
//   clk, reset         : clock, asynchronous active-high reset
//   instr_valid/instr  : instruction handshake input ([15:13] opcode, [12:0] addr)
//   instr_ready        : an instruction is accepted this cycle if instr_valid
//   acc1_full/acc2_full: accumulator full indications (may be single pulses)
//   load_weight        : one-cycle strobe after an accepted LDW
//   load_input         : one-cycle strobe after an accepted LDI
//   valid              : compute window of a MATMUL
//   base_address       : address of the last LDW/LDI/MATMUL
//   busy               : sequencer is not idle
//   done               : one-cycle pulse when a MATMUL completes normally
//   timeout_err        : sticky, a MATMUL was aborted by the timer
//   halted             : sticky, a HALT was executed
// All outputs are registered.
// -----------------------------------------------------------------------------
module tpu_sequencer #(
    parameter int TIMEOUT = 64,   // must be >= 8
    parameter int ADDR_W  = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    output logic              instr_ready,
    input  logic              acc1_full,
    input  logic              acc2_full,
    output logic              load_weight,
    output logic              load_input,
    output logic              valid,
    output logic [ADDR_W-1:0] base_address,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic              halted
);
    import tpu_pkg::*;

    seq_state_t        state_q, state_d;
    logic              instr_ready_q, instr_ready_d;
    logic              load_weight_q, load_weight_d;
    logic              load_input_q, load_input_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] base_address_q, base_address_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              timeout_err_q, timeout_err_d;
    logic              halted_q, halted_d;
    logic              f1_q, f1_d;
    logic              f2_q, f2_d;

    logic              accept;
    opcode_t           opcode;
    logic [ADDR_W-1:0] instr_addr;
    logic              timer_enable;
    logic              timer_clear;
    logic              timer_expired;

    assign accept     = instr_valid && instr_ready_q;
    assign opcode     = decode_opcode(instr);
    assign instr_addr = ADDR_W'(instr[OPC_LSB-1:0]);

    // The timer runs only in COMPUTE and is held at zero everywhere else, so
    // it reads zero in the first COMPUTE cycle.
    assign timer_enable = (state_q == ST_COMPUTE);
    assign timer_clear  = !timer_enable;

    seq_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expired(timer_expired)
    );

    always_comb begin
        // NOTE: every *_d is given a default before the case so no path leaves
        // it unassigned; a missing default here would infer a latch.
        state_d        = state_q;
        instr_ready_d  = 1'b0;
        load_weight_d  = 1'b0;
        load_input_d   = 1'b0;
        done_d         = 1'b0;
        timeout_err_d  = timeout_err_q;
        halted_d       = halted_q;
        base_address_d = base_address_q;
        f1_d           = f1_q;
        f2_d           = f2_q;

        unique case (state_q)
            ST_IDLE: begin
                instr_ready_d = !halted_q;
                if (accept) begin
                    unique case (opcode)
                        OP_LDW: begin
                            state_d        = ST_LDW;
                            load_weight_d  = 1'b1;
                            base_address_d = instr_addr;
                            instr_ready_d  = 1'b0;
                        end
                        OP_LDI: begin
                            state_d        = ST_LDI;
                            load_input_d   = 1'b1;
                            base_address_d = instr_addr;
                            instr_ready_d  = 1'b0;
                        end
                        OP_MATMUL: begin
                            state_d        = ST_COMPUTE;
                            base_address_d = instr_addr;
                            f1_d           = 1'b0;
                            f2_d           = 1'b0;
                            instr_ready_d  = 1'b0;
                        end
                        OP_HALT: begin
                            state_d       = ST_HALT;
                            halted_d      = 1'b1;
                            instr_ready_d = 1'b0;
                        end
                        default: begin
                            // NOP / illegal: consumed, stay ready.
                        end
                    endcase
                end
            end

            ST_LDW, ST_LDI: begin
                state_d       = ST_IDLE;
                instr_ready_d = 1'b1;
            end

            ST_COMPUTE: begin
                // A full seen this cycle counts together with the latched one,
                // so simultaneous pulses complete immediately.
                f1_d = f1_q || acc1_full;
                f2_d = f2_q || acc2_full;
                if (f1_d && f2_d) begin
                    state_d       = ST_IDLE;
                    done_d        = 1'b1;
                    instr_ready_d = 1'b1;
                end else if (timer_expired) begin
                    state_d       = ST_IDLE;
                    timeout_err_d = 1'b1;
                    instr_ready_d = 1'b1;
                end
            end

            ST_HALT: begin
                // Parked: not ready, no strobes, only reset leaves.
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        valid_d = (state_d == ST_COMPUTE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            instr_ready_q  <= 1'b0;
            load_weight_q  <= 1'b0;
            load_input_q   <= 1'b0;
            valid_q        <= 1'b0;
            base_address_q <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
            halted_q       <= 1'b0;
            f1_q           <= 1'b0;
            f2_q           <= 1'b0;
        end else begin
            state_q        <= state_d;
            instr_ready_q  <= instr_ready_d;
            load_weight_q  <= load_weight_d;
            load_input_q   <= load_input_d;
            valid_q        <= valid_d;
            base_address_q <= base_address_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            timeout_err_q  <= timeout_err_d;
            halted_q       <= halted_d;
            f1_q           <= f1_d;
            f2_q           <= f2_d;
        end
    end

    assign instr_ready  = instr_ready_q;
    assign load_weight  = load_weight_q;
    assign load_input   = load_input_q;
    assign valid        = valid_q;
    assign base_address = base_address_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign timeout_err  = timeout_err_q;
    assign halted       = halted_q;

endmodule

// File: tb/tb_tpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tpu_sequencer
// Self-checking bench for tpu_sequencer. The stimulus process issues
// instructions and pushes the expected observable event of each one (strobe,
// completed or aborted compute window) into a scoreboard queue; a separate
// monitor pops and compares whenever the DUT shows such an event.
// -----------------------------------------------------------------------------
module tb_tpu_sequencer;

    localparam int T = 16;

    typedef enum int {K_LW, K_LI, K_DONE, K_ABORT} ev_kind_t;

    typedef struct {
        ev_kind_t    kind;
        logic [12:0] addr;
        int          len;
        logic        err;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic        acc1_full;
    logic        acc2_full;
    logic        load_weight;
    logic        load_input;
    logic        valid;
    logic [12:0] base_address;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic        halted;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic m_err  = 1'b0;     // model: sticky timeout flag
    logic [12:0] m_addr = '0; // model: last load/matmul address
    logic mon_flush = 1'b0;

    tpu_sequencer #(
        .TIMEOUT(T),
        .ADDR_W (13)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .acc1_full   (acc1_full),
        .acc2_full   (acc2_full),
        .load_weight (load_weight),
        .load_input  (load_input),
        .valid       (valid),
        .base_address(base_address),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------ monitor
    task automatic got(input ev_kind_t kind, input int len);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event actual=%s len=%0d expected=none", kind.name(), len);
            return;
        end
        e = sb.pop_front();
        check("event_kind", 32'(kind), 32'(e.kind));
        check("event_len", 32'(len), 32'(e.len));
        check("event_addr", 32'(base_address), 32'(e.addr));
        check("event_err", 32'(timeout_err), 32'(e.err));
    endtask

    initial begin : monitor
        int run;
        bit prev_valid;
        run = 0;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (reset || mon_flush) begin
                run = 0;
                prev_valid = 1'b0;
            end else begin
                if (load_weight) got(K_LW, 0);
                if (load_input)  got(K_LI, 0);
                if (valid) begin
                    run++;
                end else if (prev_valid) begin
                    got(done ? K_DONE : K_ABORT, run);
                    run = 0;
                end else if (done) begin
                    got(K_DONE, 0);
                end
                prev_valid = valid;
            end
        end
    end

    // ----------------------------------------------------------------- stimulus
    task automatic idle_drive();
        instr_valid = 1'b0;
        instr       = 16'($urandom);
        acc1_full   = 1'($urandom_range(0, 1));
        acc2_full   = 1'($urandom_range(0, 1));
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            idle_drive();
            @(negedge clk);
        end
    endtask

    // Present an instruction from a negedge; returns just after the accepting
    // rising edge.
    task automatic handshake(input logic [15:0] ins, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            instr_valid = 1'b1;
            instr       = ins;
            acc1_full   = 1'($urandom_range(0, 1));
            acc2_full   = 1'($urandom_range(0, 1));
            if (instr_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_wait actual=no_accept expected=accept ins=%h", ins);
            instr_valid = 1'b0;
        end
    endtask

    // Issue one instruction; c1/c2 are the COMPUTE cycles (1-based) in which
    // acc1_full/acc2_full pulse for a MATMUL (values outside 1..T never land).
    task automatic issue(input logic [2:0] opc, input logic [12:0] addr, input int c1, input int c2);
        bit   ok;
        bit   fin;
        exp_t e;
        handshake({opc, addr}, ok);
        if (!ok) return;
        case (opc)
            3'b001, 3'b010: begin
                m_addr = addr;
                e.kind = (opc == 3'b001) ? K_LW : K_LI;
                e.addr = addr;
                e.len  = 0;
                e.err  = m_err;
                sb.push_back(e);
                @(negedge clk);
                idle_drive();
                check("load_ready_low", 32'(instr_ready), 0);
                check("load_busy", 32'(busy), 1);
                @(negedge clk);
                idle_drive();
                check("load_ready_back", 32'(instr_ready), 1);
            end
            3'b011: begin
                m_addr = addr;
                if (c1 >= 1 && c1 <= T && c2 >= 1 && c2 <= T) begin
                    e.kind = K_DONE;
                    e.len  = (c1 > c2) ? c1 : c2;
                end else begin
                    e.kind = K_ABORT;
                    e.len  = T;
                    m_err  = 1'b1;
                end
                e.addr = addr;
                e.err  = m_err;
                sb.push_back(e);
                @(negedge clk);
                check("mm_valid_start", 32'(valid), 1);
                check("mm_ready_low", 32'(instr_ready), 0);
                fin = 1'b0;
                for (int n = 1; n <= T + 4; n++) begin
                    // Garbage instructions while not ready must be ignored.
                    instr_valid = 1'b1;
                    instr       = 16'($urandom);
                    acc1_full   = (n == c1);
                    acc2_full   = (n == c2);
                    @(negedge clk);
                    if (!valid) begin
                        fin = 1'b1;
                        break;
                    end
                end
                instr_valid = 1'b0;
                acc1_full   = 1'b0;
                acc2_full   = 1'b0;
                check("mm_finished", 32'(fin), 1);
                check("mm_ready_after", 32'(instr_ready), 1);
            end
            3'b111: begin
                @(negedge clk);
                idle_drive();
                check("halt_set", 32'(halted), 1);
                check("halt_ready", 32'(instr_ready), 0);
                check("halt_busy", 32'(busy), 1);
            end
            default: begin
                @(negedge clk);
                idle_drive();
                check("nop_ready", 32'(instr_ready), 1);
                check("nop_busy", 32'(busy), 0);
                check("nop_addr_kept", 32'(base_address), 32'(m_addr));
            end
        endcase
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bit ok;
        logic [2:0] opc;
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        acc1_full   = 1'b0;
        acc2_full   = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_instr_ready", 32'(instr_ready), 0);
        check("rst_load_weight", 32'(load_weight), 0);
        check("rst_load_input", 32'(load_input), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_base_address", 32'(base_address), 0);

        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(instr_ready), 1);

        issue(3'b001, 13'h0004, 0, 0);          // LDW
        issue(3'b010, 13'h0010, 0, 0);          // LDI
        issue(3'b011, 13'h0020, 3, 5);          // done after 5
        issue(3'b011, 13'h0030, 2, 2);          // simultaneous fulls
        issue(3'b011, 13'h0040, 0, 0);          // timeout
        check("timeout_sticky", 32'(timeout_err), 1);

        // Fulls while idle must not produce anything.
        acc1_full = 1'b1;
        acc2_full = 1'b1;
        @(negedge clk);
        acc1_full = 1'b0;
        acc2_full = 1'b0;
        @(negedge clk);
        check("idle_fulls_no_done", 32'(done), 0);

        issue(3'b001, 13'h0050, 0, 0);          // LDW after timeout
        issue(3'b011, 13'h0060, 5, T);          // completion on last cycle wins
        issue(3'b011, 13'h0070, T + 1, 1);      // second full too late
        check("timeout_still_set", 32'(timeout_err), 1);

        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 4))
                0: opc = 3'b001;
                1: opc = 3'b010;
                2, 3: opc = 3'b011;
                default: opc = 3'($urandom_range(4, 6)) & 3'b110 | 3'($urandom_range(0, 1)) & 3'b001;
            endcase
            if (opc == 3'b111) opc = 3'b000;
            issue(opc, 13'($urandom), $urandom_range(1, T + 3), $urandom_range(1, T + 3));
            gap($urandom_range(0, 2));
        end

        // Reset in the third COMPUTE cycle.
        handshake({3'b011, 13'h0777}, ok);
        if (ok) begin
            @(negedge clk);
            instr_valid = 1'b0;
            acc1_full   = 1'b0;
            acc2_full   = 1'b0;
            check("mrst_valid_start", 32'(valid), 1);
            @(negedge clk);
            @(negedge clk);
            mon_flush = 1'b1;
            #1 reset = 1'b1;
            #1;
            check("mrst_valid_async", 32'(valid), 0);
            check("mrst_busy_async", 32'(busy), 0);
            check("mrst_ready", 32'(instr_ready), 0);
            @(negedge clk);
            @(negedge clk);
            reset  = 1'b0;
            m_err  = 1'b0;
            m_addr = '0;
            @(negedge clk);
            check("mrst_ready_back", 32'(instr_ready), 1);
            check("mrst_addr_clear", 32'(base_address), 0);
            check("mrst_err_clear", 32'(timeout_err), 0);
            mon_flush = 1'b0;
        end
        issue(3'b011, 13'h0123, 4, 4);
        check("post_rst_no_err", 32'(timeout_err), 0);

        // Illegal opcode, then HALT.
        issue(3'b101, 13'h1abc, 0, 0);
        issue(3'b111, 13'h0000, 0, 0);
        for (int i = 0; i < 20; i++) begin
            instr_valid = 1'b1;
            instr       = {3'b001, 13'(i)};
            @(negedge clk);
            check("halt_hold_ready", 32'(instr_ready), 0);
            check("halt_hold_flag", 32'(halted), 1);
        end
        instr_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("halt_rst_clear", 32'(halted), 0);
        reset = 1'b0;
        @(negedge clk);
        check("halt_rst_ready", 32'(instr_ready), 1);

        gap(3);
        check("scoreboard_empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
